alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Sequential successor to the ALU control circuit. It accepts one operation at a time over a valid/ready handshake and decodes the opcode to the datapath controller code. It holds the ALU enabled for a per-class parametrised latency, so multiply and divide can be multi-cycle. It then presents completion over a second valid/ready handshake. The block sits between the instruction/operand source and the ALU datapath.

## Interface
Parameters:
- `LOGIC_LAT`, default 1: EXEC cycles for AND, NAND, OR, NOR, XOR, XNOR and NOT. Must be ≥1.
- `ADDSUB_LAT`, default 1: EXEC cycles for addition and subtraction. Must be ≥1.
- `MUL_LAT`, default 4: EXEC cycles for multiplication. Must be ≥1.
- `DIV_LAT`, default 8: EXEC cycles for division. Must be ≥1.
- `CNT_W`, default `$clog2(max latency)+1`: latency counter width.

Ports:
- `clk`, in, 1: the only clock. All logic is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `op_valid`, in, 1: an operation is offered.
- `op_ready`, out, 1: the block can accept an operation. High only in IDLE.
- `operation_type`, in, 4: opcode, using the same encoding as the controller codes (0000 = AND … 1010 = Division).
- `controller`, out, 4: registered datapath control code.
- `alu_en`, out, 1: datapath enable. High for exactly the class latency.
- `res_valid`, out, 1: the operation has completed.
- `res_ready`, in, 1: the consumer accepts completion.
- `illegal_op`, out, 1: sticky illegal-opcode flag. This port exists only with `ALU_ILLEGAL_OP_TRAP_EN` defined.

## Operation
- States are IDLE, EXEC and DONE. They are held in a registered state variable.
- Reset values: state = IDLE, `controller` = 0000, `alu_en` = 0, `res_valid` = 0, counter = 0, `illegal_op` = 0.
- **IDLE:**
  - `op_ready` = 1.
  - On `op_valid` & `op_ready`, latch the decoded code into `controller` and load counter = latency − 1.
  - Go to EXEC.
- **EXEC:**
  - `alu_en` = 1 and `controller` is stable.
  - If counter = 0, go to DONE. Otherwise decrement the counter.
- **DONE:**
  - `res_valid` = 1, `alu_en` = 0, `controller` is held.
  - On `res_ready`, go to IDLE.
  - `res_valid` must not drop until `res_ready` is seen.
- Latency classes:
  - Opcodes 0000–0110 use `LOGIC_LAT`.
  - Opcodes 0111–1000 use `ADDSUB_LAT`.
  - Opcode 1001 uses `MUL_LAT`.
  - Opcode 1010 uses `DIV_LAT`.
- Opcodes 1011–1111 are illegal. They decode to 0000 (AND) with `LOGIC_LAT`.
- `op_valid` while not in IDLE is ignored. No operation is queued. The source must hold the operation until `op_ready`.
- `operation_type` is sampled only at acceptance. Later changes to it do not affect the operation in flight.
- Reset asserted mid-operation returns all state and outputs to their reset values immediately and asynchronously. The in-flight operation is discarded.

## Timing
- Acceptance happens at edge T. `alu_en` and the new `controller` value are visible from T+1 for L cycles. `res_valid` rises at T+1+L.
- With `res_ready` tied high, `res_valid` is high for 1 cycle and `op_ready` returns at T+2+L.
- Minimum issue interval is L+2 cycles. With default parameters that is 3 cycles for logic ops and 10 for division.
- `op_ready` is a function of state only. It has no combinational path from `op_valid`.
- `res_valid` is a function of state only. It has no combinational path from `res_ready`.

## Configuration
- Macro: `ALU_ILLEGAL_OP_TRAP_EN`.
- **Defined:**
  - An illegal opcode accepted in IDLE sets `illegal_op` at T+1.
  - `illegal_op` stays set until reset.
  - The operation still executes as AND, so the handshake is unchanged.
- **Undefined:**
  - The `illegal_op` port and its register are absent.
  - Illegal opcodes silently execute as AND.

## Structure
- Package `alu_ctrl_pkg` contains:
  - the 4-bit opcode/controller localparams (`OP_AND` … `OP_DIV`);
  - the state enum `{IDLE, EXEC, DONE}`;
  - the latency-class enum `{LAT_LOGIC, LAT_ADDSUB, LAT_MUL, LAT_DIV}`.
- One sub-module, `alu_op_decoder`, is purely combinational. It maps `operation_type` to the controller code, the latency class and the illegal flag. The sequencer instantiates it and maps the class to the parameter value.

## Test plan
- Reset, then issue AND (0000) with `res_ready` = 1 → `controller` = 0000 and `alu_en` high for 1 cycle; `res_valid` high at T+2; `op_ready` high at T+3.
- Issue Division (1010) with defaults → `alu_en` high for exactly 8 cycles with `controller` = 1010; `res_valid` rises at T+9.
- Issue Multiplication (1001) with `res_ready` held low for 5 cycles after `res_valid` → `res_valid` stays high; `op_ready` stays low; `controller` holds 1001 until `res_ready`.
- During EXEC of multiplication, drive `op_valid` = 1 with opcode 0100 → ignored; `controller` stays 1001; no second completion.
- Assert `reset` mid-EXEC of division → all outputs drop to reset values immediately; the next op issued after release completes normally.
- Issue opcode 1100 → `controller` = 0000 and latency 1. With `ALU_ILLEGAL_OP_TRAP_EN` defined, `illegal_op` = 1 from T+1 and stays set through the following legal ops until reset.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared opcode/controller codes, sequencer state and
//               latency-class types for the ALU operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_XNOR = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LAT_LOGIC  = 2'd0,
        LAT_ADDSUB = 2'd1,
        LAT_MUL    = 2'd2,
        LAT_DIV    = 2'd3
    } lat_class_t;

    function automatic int max_lat(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decoder
// Description : Combinational opcode decode to controller code and latency
//               class. Illegal flag output present with ALU_ILLEGAL_OP_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decoder
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [3:0] o_ctrl,
    output lat_class_t o_lat_class
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    ,
    output logic       o_illegal
`endif
);

    logic w_illegal;

    // Illegal opcodes fall back to AND at logic latency.
    always_comb begin
        o_ctrl      = OP_AND;
        o_lat_class = LAT_LOGIC;
        w_illegal   = 1'b0;
        case (i_op)
            OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_NOT: begin
                o_ctrl      = i_op;
                o_lat_class = LAT_LOGIC;
            end
            OP_ADD, OP_SUB: begin
                o_ctrl      = i_op;
                o_lat_class = LAT_ADDSUB;
            end
            OP_MUL: begin
                o_ctrl      = i_op;
                o_lat_class = LAT_MUL;
            end
            OP_DIV: begin
                o_ctrl      = i_op;
                o_lat_class = LAT_DIV;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef ALU_ILLEGAL_OP_TRAP_EN
    assign o_illegal = w_illegal;
`else
    logic w_unused;
    assign w_unused = w_illegal;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Valid/ready operation sequencer holding the ALU enabled for a
//               per-class latency. Optional macro: ALU_ILLEGAL_OP_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int LOGIC_LAT  = 1,
    parameter int ADDSUB_LAT = 1,
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 8,
    parameter int CNT_W      = $clog2(max_lat(LOGIC_LAT, ADDSUB_LAT, MUL_LAT, DIV_LAT)) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] operation_type,
    output logic [3:0] controller,
    output logic       alu_en,
    output logic       res_valid,
    input  logic       res_ready
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    localparam logic [CNT_W-1:0] c_LOGIC_LOAD  = CNT_W'(LOGIC_LAT - 1);
    localparam logic [CNT_W-1:0] c_ADDSUB_LOAD = CNT_W'(ADDSUB_LAT - 1);
    localparam logic [CNT_W-1:0] c_MUL_LOAD    = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD    = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_controller;
    logic             r_alu_en;
    logic             r_res_valid;
    logic [3:0]       w_dec_ctrl;
    lat_class_t       w_lat_class;
    logic [CNT_W-1:0] w_load;

`ifdef ALU_ILLEGAL_OP_TRAP_EN
    logic w_dec_illegal;
    logic r_illegal;

    alu_op_decoder u_dec (
        .i_op        (operation_type),
        .o_ctrl      (w_dec_ctrl),
        .o_lat_class (w_lat_class),
        .o_illegal   (w_dec_illegal)
    );

    assign illegal_op = r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (r_state == IDLE && op_valid && w_dec_illegal) begin
            r_illegal <= 1'b1;
        end
    end
`else
    alu_op_decoder u_dec (
        .i_op        (operation_type),
        .o_ctrl      (w_dec_ctrl),
        .o_lat_class (w_lat_class)
    );
`endif

    always_comb begin
        w_load = c_LOGIC_LOAD;
        case (w_lat_class)
            LAT_LOGIC:  w_load = c_LOGIC_LOAD;
            LAT_ADDSUB: w_load = c_ADDSUB_LOAD;
            LAT_MUL:    w_load = c_MUL_LOAD;
            LAT_DIV:    w_load = c_DIV_LOAD;
            default:    w_load = c_LOGIC_LOAD;
        endcase
    end

    // Counter holds remaining EXEC cycles minus one; zero means last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_controller <= OP_AND;
            r_alu_en     <= 1'b0;
            r_res_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_valid) begin
                        r_controller <= w_dec_ctrl;
                        r_cnt        <= w_load;
                        r_alu_en     <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_alu_en    <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_alu_en    <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready   = (r_state == IDLE);
    assign controller = r_controller;
    assign alu_en     = r_alu_en;
    assign res_valid  = r_res_valid;

endmodule
`default_nettype wire
